mem_arbiter: RTL and testbench

Sequential arbiter sharing the single main-memory port between the instruction cache and the data cache. Accepts one block request at a time from either cache, latches its address/data, drives the memory handshake (read/write/busywait) to completion, and returns data plus a busywait release to the winning cache only. Sits between both caches and the data memory; the CPU stalls through the caches' own busywait outputs.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_pick.sv | 28 ++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data cache memory arbiter.
// Provides the arbiter FSM state type, default block address/data widths
// and the requester IDs used by the priority pointer.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 32;

  // Requester IDs, also the encoding of the one-bit priority pointer.
  localparam logic REQ_D = 1'b0;
  localparam logic REQ_I = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    D_REQ,
    D_WAIT,
    D_DONE,
    I_REQ,
    I_WAIT,
    I_DONE
  } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// Two-way combinational request picker.
// Ports:
//   req_d, req_i     : pending requests from D-cache / I-cache
//   ptr              : requester favoured when both request (REQ_D / REQ_I)
//   grant_d, grant_i : one-hot (or zero) grant
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic req_d,
  input  logic req_i,
  input  logic ptr,
  output logic grant_d,
  output logic grant_i
);

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (req_d && req_i) begin
      grant_d = (ptr == REQ_D);
      grant_i = (ptr == REQ_I);
    end else begin
      grant_d = req_d;
      grant_i = req_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Sequential arbiter sharing the single main-memory port between the
// instruction cache and the data cache. One block transaction at a time:
// the winner's address/data are latched, the memory handshake is run to
// completion and the winner alone gets its read data and a one-cycle
// busywait release.
// Ports:
//   CLK, RESET                      : clock, async active-high reset
//   DREAD/DWRITE/DADDRESS/DWRITEDATA: D-cache request
//   DREADDATA/DBUSYWAIT             : D-cache response / stall
//   IREAD/IADDRESS                  : I-cache request
//   IREADDATA/IBUSYWAIT             : I-cache response / stall
//   MEM_*                           : main-memory port
// Build option: define ARB_ROUND_ROBIN_EN to alternate priority after each
// completed transaction; otherwise the D-cache always wins ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DREAD,
  input  logic              DWRITE,
  input  logic [ADDR_W-1:0] DADDRESS,
  input  logic [DATA_W-1:0] DWRITEDATA,
  output logic [DATA_W-1:0] DREADDATA,
  output logic              DBUSYWAIT,
  input  logic              IREAD,
  input  logic [ADDR_W-1:0] IADDRESS,
  output logic [DATA_W-1:0] IREADDATA,
  output logic              IBUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic              ptr;
  logic              grant_d, grant_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = REQ_D;
`endif

  arb_pick u_pick (
    .req_d   (DREAD | DWRITE),
    .req_i   (IREAD),
    .ptr     (ptr),
    .grant_d (grant_d),
    .grant_i (grant_i)
  );

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      drdata_q <= '0;
      irdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      drdata_q <= drdata_d;
      irdata_q <= irdata_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr_q <= REQ_D;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Next-state and latch-enable logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    drdata_d = drdata_q;
    irdata_d = irdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = D_REQ;
          addr_d  = DADDRESS;
          wdata_d = DWRITEDATA;
          wr_d    = DWRITE;   // write wins when DREAD and DWRITE are both set
        end else if (grant_i) begin
          state_d = I_REQ;
          addr_d  = IADDRESS;
          wr_d    = 1'b0;
        end
      end
      D_REQ:  if (MEM_BUSYWAIT) state_d = D_WAIT;
      D_WAIT: begin
        if (!MEM_BUSYWAIT) begin
          state_d = D_DONE;
          if (!wr_q) drdata_d = MEM_READDATA;
        end
      end
      D_DONE: begin
        state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d   = REQ_I;
`endif
      end
      I_REQ:  if (MEM_BUSYWAIT) state_d = I_WAIT;
      I_WAIT: begin
        if (!MEM_BUSYWAIT) begin
          state_d  = I_DONE;
          irdata_d = MEM_READDATA;
        end
      end
      I_DONE: begin
        state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d   = REQ_D;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state, so a reset drops the
  // memory command immediately without waiting for a clock edge.
  always_comb begin
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = addr_q;
    MEM_WRITEDATA = wdata_q;
    DREADDATA     = drdata_q;
    IREADDATA     = irdata_q;
    DBUSYWAIT     = (DREAD | DWRITE) & (state_q != D_DONE);
    IBUSYWAIT     = IREAD & (state_q != I_DONE);
    unique case (state_q)
      D_REQ, D_WAIT: begin
        MEM_READ  = ~wr_q;
        MEM_WRITE = wr_q;
      end
      I_REQ, I_WAIT: MEM_READ = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        DREAD, DWRITE, IREAD;
  logic [5:0]  DADDRESS, IADDRESS;
  logic [31:0] DWRITEDATA;
  logic [31:0] DREADDATA, IREADDATA;
  logic        DBUSYWAIT, IBUSYWAIT;
  logic        MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .DREAD         (DREAD),
    .DWRITE        (DWRITE),
    .DADDRESS      (DADDRESS),
    .DWRITEDATA    (DWRITEDATA),
    .DREADDATA     (DREADDATA),
    .DBUSYWAIT     (DBUSYWAIT),
    .IREAD         (IREAD),
    .IADDRESS      (IADDRESS),
    .IREADDATA     (IREADDATA),
    .IBUSYWAIT     (IBUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Memory model: 5 busy cycles per access, ignores a still-asserted
  // command after completion until the command drops.
  logic [31:0] mem [64];
  logic        m_active, m_cool, m_wr;
  logic [2:0]  m_cnt;
  logic [5:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  assign MEM_BUSYWAIT = m_active;
  assign MEM_READDATA = m_rdata;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[6'h05] = 32'hDEADBEEF;
    mem[6'h3F] = 32'h12345678;
    mem[6'h01] = 32'hA5A5_0001;
  end

  always @(posedge CLK) begin
    if (RESET) begin
      m_active <= 1'b0;
      m_cool   <= 1'b0;
      m_cnt    <= '0;
      m_rdata  <= '0;
    end else if (!m_active && !m_cool && (MEM_READ || MEM_WRITE)) begin
      m_active <= 1'b1;
      m_cnt    <= 3'd5;
      m_addr   <= MEM_ADDRESS;
      m_wr     <= MEM_WRITE;
      m_wdata  <= MEM_WRITEDATA;
    end else if (m_active) begin
      if (m_cnt == 3'd1) begin
        m_active <= 1'b0;
        m_cool   <= 1'b1;
        if (m_wr) mem[m_addr] <= m_wdata;
        else      m_rdata <= mem[m_addr];
      end else begin
        m_cnt <= m_cnt - 3'd1;
      end
    end else if (m_cool && !(MEM_READ || MEM_WRITE)) begin
      m_cool <= 1'b0;
    end
  end

  // Scoreboard of memory commands in expected issue order.
  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } cmd_t;
  cmd_t exp_q[$];
  logic cmd_prev = 1'b0;

  always @(negedge CLK) begin
    cmd_t e;
    if ((MEM_READ || MEM_WRITE) && !cmd_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd", {26'd0, MEM_ADDRESS}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("cmd_wr",   {31'd0, MEM_WRITE}, {31'd0, e.wr});
        chk("cmd_rd",   {31'd0, MEM_READ},  {31'd0, ~e.wr});
        chk("cmd_addr", {26'd0, MEM_ADDRESS}, {26'd0, e.addr});
        if (e.wr) chk("cmd_wdata", MEM_WRITEDATA, e.data);
      end
    end
    cmd_prev <= MEM_READ || MEM_WRITE;
  end

  bit rr_en;
  bit model_ptr;   // 0 = D favoured, 1 = I favoured

  task automatic push_cmd(input logic wr, input logic [5:0] a, input logic [31:0] d);
    cmd_t c;
    c.wr = wr; c.addr = a; c.data = d;
    exp_q.push_back(c);
  endtask

  // Runs the caches' side of the handshake until every pending request is
  // released; checks returned data, loser stall and one-cycle release.
  task automatic serve(input bit dp, input bit ip, input logic [31:0] dexp,
                       input logic [31:0] iexp);
    bit d_drop = 0, i_drop = 0;
    int cyc = 0;
    while ((dp || ip || d_drop || i_drop) && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (d_drop) begin
        chk("d_release_one_cycle", {31'd0, DBUSYWAIT}, 32'd1);
        DREAD = 0; DWRITE = 0; d_drop = 0;
      end
      if (i_drop) begin
        chk("i_release_one_cycle", {31'd0, IBUSYWAIT}, 32'd1);
        IREAD = 0; i_drop = 0;
      end
      if (dp && !DBUSYWAIT) begin
        chk("d_rdata", DREADDATA, dexp);
        if (ip) chk("i_stalled_during_d", {31'd0, IBUSYWAIT}, 32'd1);
        dp = 0; d_drop = 1; model_ptr = 1;
      end
      if (ip && !IBUSYWAIT) begin
        chk("i_rdata", IREADDATA, iexp);
        if (dp) chk("d_stalled_during_i", {31'd0, DBUSYWAIT}, 32'd1);
        ip = 0; i_drop = 1; model_ptr = 0;
      end
    end
    if (cyc >= 200) chk("serve_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] last_i;
    bit          d_first;
`ifdef ARB_ROUND_ROBIN_EN
    rr_en = 1;
`else
    rr_en = 0;
`endif
    model_ptr = 0;
    RESET = 1; DREAD = 0; DWRITE = 0; IREAD = 0;
    DADDRESS = '0; IADDRESS = '0; DWRITEDATA = '0;
    repeat (2) @(negedge CLK);
    chk("rst_mem_read",  {31'd0, MEM_READ},  32'd0);
    chk("rst_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    chk("rst_mem_addr",  {26'd0, MEM_ADDRESS}, 32'd0);
    chk("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
    chk("rst_dreaddata", DREADDATA, 32'd0);
    chk("rst_ireaddata", IREADDATA, 32'd0);
    chk("rst_dbusy",     {31'd0, DBUSYWAIT}, 32'd0);
    chk("rst_ibusy",     {31'd0, IBUSYWAIT}, 32'd0);
    RESET = 0;
    @(negedge CLK);

    // D read alone, with grant latency check.
    DREAD = 1; DADDRESS = 6'h05;
    push_cmd(0, 6'h05, '0);
    @(negedge CLK);
    chk("grant_latency", {31'd0, MEM_READ}, 32'd1);
    serve(1, 0, 32'hDEADBEEF, 32'd0);

    // I read alone; D data untouched.
    IREAD = 1; IADDRESS = 6'h3F;
    push_cmd(0, 6'h3F, '0);
    serve(0, 1, 32'hDEADBEEF, 32'h12345678);
    chk("dreaddata_kept", DREADDATA, 32'hDEADBEEF);
    last_i = 32'h12345678;

    // Simultaneous D write and I read.
    d_first = !rr_en || (model_ptr == 0);
    DWRITE = 1; DADDRESS = 6'h0A; DWRITEDATA = 32'hCAFEF00D;
    IREAD = 1; IADDRESS = 6'h01;
    if (d_first) begin
      push_cmd(1, 6'h0A, 32'hCAFEF00D); push_cmd(0, 6'h01, '0);
    end else begin
      push_cmd(0, 6'h01, '0); push_cmd(1, 6'h0A, 32'hCAFEF00D);
    end
    serve(1, 1, 32'hDEADBEEF, 32'hA5A5_0001);
    last_i = 32'hA5A5_0001;

    // Read back the written block.
    DREAD = 1; DADDRESS = 6'h0A;
    push_cmd(0, 6'h0A, '0);
    serve(1, 0, 32'hCAFEF00D, last_i);

    // Requester address changes after grant.
    DREAD = 1; DADDRESS = 6'h05;
    push_cmd(0, 6'h05, '0);
    repeat (3) @(negedge CLK);
    DADDRESS = 6'h22;
    repeat (2) @(negedge CLK);
    chk("addr_held", {26'd0, MEM_ADDRESS}, 32'd5);
    chk("cmd_held",  {31'd0, MEM_READ}, 32'd1);
    serve(1, 0, 32'hDEADBEEF, last_i);

    // Contested rounds.
    for (int r = 0; r < 3; r++) begin
      logic [5:0] da, ia;
      da = 6'h10 + 6'(r);
      ia = 6'h20 + 6'(r);
      d_first = !rr_en || (model_ptr == 0);
      DREAD = 1; DADDRESS = da; IREAD = 1; IADDRESS = ia;
      if (d_first) begin
        push_cmd(0, da, '0); push_cmd(0, ia, '0);
      end else begin
        push_cmd(0, ia, '0); push_cmd(0, da, '0);
      end
      serve(1, 1, 32'h1000_0000 + 32'(da), 32'h1000_0000 + 32'(ia));
      last_i = 32'h1000_0000 + 32'(ia);
    end

    // Reset in the middle of a D read.
    DREAD = 1; DADDRESS = 6'h05;
    push_cmd(0, 6'h05, '0);
    repeat (4) @(negedge CLK);
    chk("pre_abort_cmd", {31'd0, MEM_READ}, 32'd1);
    RESET = 1;
    #1;
    chk("abort_mem_read",  {31'd0, MEM_READ}, 32'd0);
    chk("abort_dreaddata", DREADDATA, 32'd0);
    chk("abort_dbusy",     {31'd0, DBUSYWAIT}, 32'd1);
    DREAD = 0;
    model_ptr = 0;
    repeat (2) @(negedge CLK);
    RESET = 0;
    @(negedge CLK);

    // Recovery after abort.
    DREAD = 1; DADDRESS = 6'h05;
    push_cmd(0, 6'h05, '0);
    serve(1, 0, 32'hDEADBEEF, 32'd0);
    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
